// File: rtl/hdmi_period_encoder.sv
// hdmi_period_encoder: TMDS encoder that inserts the HDMI video preamble and leading guard band before each video period.
// Define TMDS_DISP_MON_EN to add the disp_mon running-disparity output.
module hdmi_period_encoder #(
   parameter int PREAMBLE_LEN = 8,
   parameter int GUARD_LEN    = 2,
   parameter int MIN_CTRL     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [23:0] video_data,
   input  logic        err_clr,
   output logic [29:0] tmds,
`ifdef TMDS_DISP_MON_EN
   output logic [14:0] disp_mon,
`endif
   output logic        lead_err
);
   localparam int D   = PREAMBLE_LEN + GUARD_LEN + 1;
   localparam int THR = PREAMBLE_LEN + GUARD_LEN + MIN_CTRL;
   localparam logic [9:0] C00 = 10'b1101010100;
   localparam logic [9:0] C01 = 10'b0010101011;
   localparam logic [9:0] C10 = 10'b0101010100;
   localparam logic [9:0] C11 = 10'b1010101011;
   localparam logic [9:0] GB0 = 10'b1011001100;
   localparam logic [9:0] GB1 = 10'b0100110011;

   typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, VIDEO} state_t;

   state_t      state_q;
   logic [3:0]  phase_q;
   logic [4:0]  run_q;
   logic        lead_err_q;
   logic [26:0] dly_q [D];
   logic [29:0] tmds_q, tmds_d;
   logic [4:0]  cnt_q [3];
   logic [4:0]  cnt_d [3];
   logic [14:0] e [3];
   logic        rise, long_lead, vid, dde, dhs, dvs;
   logic [23:0] dpx;
   logic [9:0]  ctl;

   // Returns {updated running disparity, 10-bit symbol}; disparity is 5-bit two's complement.
   function automatic logic [14:0] enc(input logic [7:0] d, input logic [4:0] c);
      logic [8:0] qm;
      logic [3:0] n1;
      logic [4:0] diff, cn;
      logic [9:0] sym;
      logic       xn;
      xn = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : qm[i-1] ^ d[i];
      qm[8] = ~xn;
      n1 = 4'($countones(qm[7:0]));
      diff = {n1, 1'b0} - 5'd8;
      if (c == 5'd0 || n1 == 4'd4) begin
         sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cn = qm[8] ? c + diff : c - diff;
      end else if ((!c[4] && n1 > 4'd4) || (c[4] && n1 < 4'd4)) begin
         sym = {1'b1, qm[8], ~qm[7:0]};
         cn = c + {3'b0, qm[8], 1'b0} - diff;
      end else begin
         sym = {1'b0, qm[8], qm[7:0]};
         cn = c + diff - {3'b0, ~qm[8], 1'b0};
      end
      return {cn, sym};
   endfunction

   always_comb begin
      {dde, dvs, dhs, dpx} = dly_q[D-1];
      rise = de && !dly_q[0][26];
      long_lead = int'(run_q) >= THR;
      vid = dde && state_q != PREAMBLE && state_q != GUARD;
      ctl = {dvs, dhs} == 2'b00 ? C00 : {dvs, dhs} == 2'b01 ? C01 : {dvs, dhs} == 2'b10 ? C10 : C11;
      for (int i = 0; i < 3; i++) begin
         e[i] = enc(dpx[8*i +: 8], cnt_q[i]);
         cnt_d[i] = vid ? e[i][14:10] : 5'd0;
      end
      tmds_d = state_q == PREAMBLE ? {C00, C01, ctl} :
               state_q == GUARD    ? {GB0, GB1, GB0} :
               vid                 ? {e[2][9:0], e[1][9:0], e[0][9:0]} : {C00, C00, ctl};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CTRL;
         phase_q <= '0;
         run_q <= '0;
         lead_err_q <= 1'b0;
         tmds_q <= {3{C00}};
         for (int i = 0; i < D; i++) dly_q[i] <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         dly_q[0] <= {de, vsync, hsync, video_data};
         for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
         run_q <= de ? 5'd0 : run_q + {4'd0, run_q != 5'd31};
         lead_err_q <= !err_clr && (lead_err_q || (rise && !long_lead));
         tmds_q <= tmds_d;
         cnt_q <= cnt_d;
         case (state_q)
            CTRL: begin
               if (rise && long_lead) state_q <= PREAMBLE;
               phase_q <= '0;
            end
            PREAMBLE: begin
               phase_q <= phase_q == 4'(PREAMBLE_LEN - 1) ? 4'd0 : phase_q + 4'd1;
               if (phase_q == 4'(PREAMBLE_LEN - 1)) state_q <= GUARD;
            end
            GUARD: begin
               phase_q <= phase_q == 4'(GUARD_LEN - 1) ? 4'd0 : phase_q + 4'd1;
               if (phase_q == 4'(GUARD_LEN - 1)) state_q <= VIDEO;
            end
            default: if (!dde) state_q <= CTRL;
         endcase
      end
   end

   assign tmds = tmds_q;
   assign lead_err = lead_err_q;
`ifdef TMDS_DISP_MON_EN
   assign disp_mon = {cnt_q[2], cnt_q[1], cnt_q[0]};
`endif
endmodule

// File: tb/tb_hdmi_period_encoder.sv
// tb_hdmi_period_encoder: directed and randomized bench for hdmi_period_encoder against a stream-level model.
module tb_hdmi_period_encoder;
   localparam int P = 8, G = 2, MC = 4, D = P + G + 1, THR = P + G + MC, MAXC = 8192;
   localparam logic [9:0] C00 = 10'b1101010100;
   localparam logic [9:0] C01 = 10'b0010101011;
   localparam logic [9:0] C10 = 10'b0101010100;
   localparam logic [9:0] C11 = 10'b1010101011;
   localparam logic [9:0] GB0 = 10'b1011001100;
   localparam logic [9:0] GB1 = 10'b0100110011;

   logic clk = 0, rst = 1, de = 0, hsync = 0, vsync = 0, err_clr = 0;
   logic [23:0] video_data = 0;
   logic [29:0] tmds;
   logic lead_err;
`ifdef TMDS_DISP_MON_EN
   logic [14:0] disp_mon;
`endif

   hdmi_period_encoder #(.PREAMBLE_LEN(P), .GUARD_LEN(G), .MIN_CTRL(MC)) dut (
      .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
      .video_data(video_data), .err_clr(err_clr), .tmds(tmds),
`ifdef TMDS_DISP_MON_EN
      .disp_mon(disp_mon),
`endif
      .lead_err(lead_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, cyc = 0, base = 0, m_err = 0, vid_cnt = 0;
   int rcnt [3];
   int ovr [MAXC];
   logic h_de [MAXC];
   logic h_hs [MAXC];
   logic h_vs [MAXC];
   logic [23:0] h_px [MAXC];
   logic [9:0] ctab [4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
   endtask

   task automatic ref_enc(input int ch, input logic [7:0] d, output logic [9:0] s);
      logic [7:0] q;
      logic q8, xn;
      int n1, m1, c;
      n1 = $countones(d);
      xn = n1 > 4 || (n1 == 4 && !d[0]);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
      q8 = !xn;
      m1 = $countones(q);
      c = rcnt[ch];
      if (c == 0 || m1 == 4) begin
         s = {!q8, q8, q8 ? q : ~q};
         c += q8 ? 2*m1 - 8 : 8 - 2*m1;
      end else if ((c > 0 && m1 > 4) || (c < 0 && m1 < 4)) begin
         s = {1'b1, q8, ~q};
         c += 2*int'(q8) + 8 - 2*m1;
      end else begin
         s = {1'b0, q8, q};
         c += 2*m1 - 8 - 2*int'(!q8);
      end
      rcnt[ch] = c;
   endtask

   task automatic model_out(input int k, output logic [29:0] s, output logic [14:0] cm);
      int src;
      logic d, h, v;
      logic [23:0] px;
      logic [9:0] e [3];
      src = k - D;
      d = 0; h = 0; v = 0; px = 0;
      if (src >= base) begin
         d = h_de[src]; h = h_hs[src]; v = h_vs[src]; px = h_px[src];
      end
      if (ovr[k] == 1) s = {C00, C01, ctab[{v, h}]};
      else if (ovr[k] == 2) s = {GB0, GB1, GB0};
      else if (d) begin
         for (int ch = 0; ch < 3; ch++) ref_enc(ch, px[8*ch +: 8], e[ch]);
         s = {e[2], e[1], e[0]};
         vid_cnt++;
      end else s = {C00, C00, ctab[{v, h}]};
      if (ovr[k] != 0 || !d) for (int ch = 0; ch < 3; ch++) rcnt[ch] = 0;
      cm = {5'(rcnt[2]), 5'(rcnt[1]), 5'(rcnt[0])};
   endtask

   task automatic step(input logic d, input logic h, input logic v, input logic [23:0] px, input logic c);
      int t, run;
      logic prev;
      logic [29:0] es;
      logic [14:0] cm;
      t = cyc + 1;
      de = d; hsync = h; vsync = v; video_data = px; err_clr = c;
      h_de[t] = d; h_hs[t] = h; h_vs[t] = v; h_px[t] = px;
      prev = (t - 1 >= base) ? h_de[t-1] : 1'b0;
      run = 0;
      for (int j = t - 1; j >= base && run < 31 && !h_de[j]; j--) run++;
      if (c) m_err = 0;
      else if (d && !prev && run < THR) m_err = 1;
      if (d && !prev && run >= THR) for (int j = 1; j <= P + G; j++) ovr[t+j] = j <= P ? 1 : 2;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      model_out(cyc, es, cm);
      chk("tmds", tmds, es);
      chk("lead_err", lead_err, m_err);
`ifdef TMDS_DISP_MON_EN
      chk("disp_mon", disp_mon, cm);
      for (int ch = 0; ch < 3; ch++) begin
         int f;
         f = $signed(disp_mon[5*ch +: 5]);
         chk("cnt_bound", 32'(f >= -10 && f <= 10), 1);
      end
`endif
   endtask

   task automatic do_reset();
      rst = 1;
      #1;
      chk("rst_tmds", tmds, {3{C00}});
      chk("rst_err", lead_err, 0);
      for (int i = cyc + 1; i < MAXC; i++) ovr[i] = 0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("rst_hold", tmds, {3{C00}});
      rst = 0;
      base = cyc + 1;
      m_err = 0;
      for (int ch = 0; ch < 3; ch++) rcnt[ch] = 0;
   endtask

   initial begin
      int lo, hi;
      int seq [3];
      seq = '{-8, 2, -6};
      ctab = '{C00, C01, C10, C11};
      for (int ch = 0; ch < 3; ch++) rcnt[ch] = 0;
      for (int i = 0; i < MAXC; i++) begin
         ovr[i] = 0; h_de[i] = 0; h_hs[i] = 0; h_vs[i] = 0; h_px[i] = 0;
      end
      @(negedge clk);
      do_reset();
      // control period with hsync high
      repeat (40) step(0, 1, 0, 0, 0);
      chk("ctrl_hs", tmds, {C00, C00, C01});
      // qualified rise: preamble, guard, then alternating encodings of 0x00
      repeat (20) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         step(i < 4, 0, 0, 0, 0);
         if (i >= 1 && i <= P) chk("pre_ch1", tmds[19:10], C01);
         if (i > P && i <= P + G) chk("guard", tmds, {GB0, GB1, GB0});
         if (i > P + G && i <= P + G + 4) chk("vid_ch0", tmds[9:0], (i % 2) ? 10'h100 : 10'h3FF);
`ifdef TMDS_DISP_MON_EN
         if (i > P + G && i <= P + G + 3) chk("disp_seq", disp_mon[4:0], 5'(seq[i-P-G-1]));
`endif
      end
      repeat (20) step(0, 0, 0, 0, 0);
      // short lead-in: no insertion, sticky error, err_clr and its priority
      repeat (4) step(1, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("err_set", lead_err, 1);
      for (int j = 1; j <= 12; j++) begin
         step(j < 4, 0, 0, 0, j == 5);
         if (j == 5) chk("err_clr", lead_err, 0);
         if (j == 10) chk("no_insert", tmds, {3{C00}});
         if (j == 11) chk("short_vid", tmds[9:0], 10'h100);
      end
      step(1, 0, 0, 0, 1);
      chk("clr_prio", lead_err, 0);
      repeat (20) step(0, 0, 0, 0, 0);
      // randomized periods
      while (vid_cnt < 1100 && cyc < 6000) begin
         lo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 13) : $urandom_range(14, 30);
         hi = $urandom_range(1, 40);
         repeat (lo) step(0, 1'($urandom), 1'($urandom), 24'($urandom), $urandom_range(0, 15) == 0);
         repeat (hi) step(1, 1'($urandom), 1'($urandom), 24'($urandom), $urandom_range(0, 15) == 0);
      end
      repeat (20) step(0, 0, 0, 0, 1);
      // reset in the middle of a preamble
      repeat (20) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 24'h123456, 0);
      repeat (6) step(0, 0, 0, 0, 0);
      do_reset();
      repeat (8) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 24'hABCDEF, 0);
      chk("fresh_run", lead_err, 1);
      repeat (20) step(0, 0, 0, 0, 1);
      step(1, 1, 1, 24'h0F0F0F, 0);
      step(1, 1, 1, 24'hF0F0F0, 0);
      chk("pre_after_rst", tmds[19:10], C01);
      repeat (4) step(1, 0, 0, 24'($urandom), 0);
      repeat (20) step(0, 0, 1, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
